// File: rtl/sine_dds_ctrl.sv
// sine_dds_ctrl: phase-accumulator sequencer for a 128-entry sine ROM.
// Steps ROM addresses by a tuning word, counts periods and tags ROM output as valid.
module sine_dds_ctrl #(
   parameter int ACC_W   = 24,
   parameter int CNT_W   = 16,
   parameter int ROM_LAT = 1
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             start,
   input  logic             stop,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [ACC_W-1:0] cfg_ftw,
   input  logic [CNT_W-1:0] cfg_cycles,
   output logic [7:0]       rom_addr,
   input  logic [15:0]      rom_data,
   output logic             samp_valid,
   output logic [15:0]      samp_data,
   output logic             busy,
   output logic             cycle_wrap,
   output logic             done
);
   localparam int               FL_W     = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
   localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(ROM_LAT - 1);
   localparam logic [FL_W-1:0]  FL_ONE   = FL_W'(1);
   localparam logic [FL_W-1:0]  FL_ZERO  = {FL_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2,
      FLUSH  = 2'd3
   } state_t;

   state_t             state_r;
   logic [ACC_W-1:0]   acc_r;
   logic [ACC_W-1:0]   ftw_r;
   logic [ACC_W-1:0]   sh_ftw_r;
   logic [CNT_W-1:0]   cycles_r;
   logic [CNT_W-1:0]   sh_cycles_r;
   logic [CNT_W-1:0]   count_r;
   logic               sh_full_r;
   logic [FL_W-1:0]    flush_cnt_r;
   logic [ROM_LAT-1:0] issue_pipe_r;
   logic               cfg_ready_r;
   logic               busy_r;
   logic               cycle_wrap_r;
   logic               done_r;

   logic [ACC_W:0]     sum_s;
   logic               carry_s;
   logic               last_s;
   logic               cfg_hs_s;
   logic               issue_s;

   // Next phase, period-end carry, final-period and handshake decode
   always_comb begin
      sum_s    = {1'b0, acc_r} + {1'b0, ftw_r};
      carry_s  = sum_s[ACC_W];
      last_s   = (cycles_r != CNT_ZERO) && (count_r == (cycles_r - CNT_ONE));
      cfg_hs_s = cfg_valid && cfg_ready_r;
      issue_s  = (state_r == RUN) || (state_r == FINISH);
   end

   // Sequencer FSM: config loading, phase stepping, period counting, termination
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_r      <= IDLE;
         acc_r        <= ACC_ZERO;
         ftw_r        <= ACC_ZERO;
         sh_ftw_r     <= ACC_ZERO;
         cycles_r     <= CNT_ZERO;
         sh_cycles_r  <= CNT_ZERO;
         count_r      <= CNT_ZERO;
         sh_full_r    <= 1'b0;
         flush_cnt_r  <= FL_ZERO;
         cfg_ready_r  <= 1'b1;
         busy_r       <= 1'b0;
         cycle_wrap_r <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         cycle_wrap_r <= 1'b0;
         done_r       <= 1'b0;
         case (state_r)
            IDLE: begin
               cfg_ready_r <= 1'b1;
               if (cfg_hs_s) begin
                  ftw_r    <= cfg_ftw;
                  cycles_r <= cfg_cycles;
               end
               if (start && (ftw_r != ACC_ZERO)) begin
                  state_r <= RUN;
                  busy_r  <= 1'b1;
                  acc_r   <= ACC_ZERO;
                  count_r <= CNT_ZERO;
               end
            end
            RUN, FINISH: begin
               if (cfg_hs_s) begin
                  sh_ftw_r    <= cfg_ftw;
                  sh_cycles_r <= cfg_cycles;
               end
               if (carry_s) begin
                  // A new tuning word takes effect from the first address of the next period
                  cycle_wrap_r <= 1'b1;
                  count_r      <= count_r + CNT_ONE;
                  if (sh_full_r) begin
                     ftw_r    <= sh_ftw_r;
                     cycles_r <= sh_cycles_r;
                  end
                  sh_full_r <= cfg_hs_s;
                  if (last_s || (state_r == FINISH) || stop) begin
                     state_r     <= FLUSH;
                     acc_r       <= ACC_ZERO;
                     flush_cnt_r <= FL_ZERO;
                     cfg_ready_r <= 1'b0;
                  end else begin
                     acc_r       <= sum_s[ACC_W-1:0];
                     cfg_ready_r <= !cfg_hs_s;
                  end
               end else begin
                  acc_r       <= sum_s[ACC_W-1:0];
                  sh_full_r   <= sh_full_r || cfg_hs_s;
                  cfg_ready_r <= !(sh_full_r || cfg_hs_s);
                  if (stop && (state_r == RUN)) begin
                     state_r <= FINISH;
                  end
               end
            end
            FLUSH: begin
               if (sh_full_r) begin
                  ftw_r     <= sh_ftw_r;
                  cycles_r  <= sh_cycles_r;
                  sh_full_r <= 1'b0;
               end
               if (flush_cnt_r == FL_LAST) begin
                  state_r     <= IDLE;
                  busy_r      <= 1'b0;
                  done_r      <= 1'b1;
                  cfg_ready_r <= 1'b1;
               end else begin
                  flush_cnt_r <= flush_cnt_r + FL_ONE;
                  cfg_ready_r <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Delay the issue flag by the ROM latency so it lines up with rom_data
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         issue_pipe_r <= {ROM_LAT{1'b0}};
      end else begin
         issue_pipe_r[0] <= issue_s;
         for (int i = 1; i < ROM_LAT; i++) begin
            issue_pipe_r[i] <= issue_pipe_r[i-1];
         end
      end
   end

   assign rom_addr   = {1'b0, acc_r[ACC_W-1 -: 7]};
   assign samp_valid = issue_pipe_r[ROM_LAT-1];
   assign samp_data  = rom_data;
   assign cfg_ready  = cfg_ready_r;
   assign busy       = busy_r;
   assign cycle_wrap = cycle_wrap_r;
   assign done       = done_r;

endmodule

// File: tb/tb_sine_dds_ctrl.sv
// tb_sine_dds_ctrl: directed runs of the DDS sequencer against a sine ROM model,
// with per-cycle expectations built from period/phase arithmetic.
module tb_sine_dds_ctrl;
   localparam logic [23:0] F17   = 24'h02_0000;
   localparam logic [23:0] F18   = 24'h04_0000;
   localparam longint      TWO24 = 64'd16777216;

   logic        clk = 1'b0;
   logic        nreset;
   logic        start;
   logic        stop;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [23:0] cfg_ftw;
   logic [15:0] cfg_cycles;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic        samp_valid;
   logic [15:0] samp_data;
   logic        busy;
   logic        cycle_wrap;
   logic        done;

   sine_dds_ctrl dut (
      .clk        (clk),
      .nreset     (nreset),
      .start      (start),
      .stop       (stop),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ftw    (cfg_ftw),
      .cfg_cycles (cfg_cycles),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .samp_valid (samp_valid),
      .samp_data  (samp_data),
      .busy       (busy),
      .cycle_wrap (cycle_wrap),
      .done       (done)
   );

   always #5 clk = ~clk;

   logic [15:0] rom [128];
   initial begin
      for (int i = 0; i < 128; i++) begin
         rom[7'(i)] = 16'($rtoi(800.0 + 632.0 * $sin(2.0 * 3.14159265358979 * i / 128.0) + 0.5));
      end
   end

   // Registered sine ROM; its reset output is 800
   always @(posedge clk or negedge nreset) begin
      if (!nreset) rom_data <= 16'd800;
      else         rom_data <= rom[rom_addr[6:0]];
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   typedef struct {
      logic [7:0]  addr;
      logic        sv;
      logic [15:0] sd;
      logic        wrap;
      logic        dn;
      logic        bs;
   } exp_t;

   exp_t        exp_q[$];
   int          addr_q[$];
   bit          last_q[$];
   int          nv;
   int          nw;
   logic [15:0] dlog[$];

   // Append n full periods of addresses stepping by ftw; phase residue carries over
   task automatic add_periods(input int n, input logic [23:0] ftw, inout longint ph);
      for (int p = 0; p < n; p++) begin
         while (ph < TWO24) begin
            addr_q.push_back(int'(ph >> 17));
            last_q.push_back(1'b0);
            ph = ph + longint'(ftw);
         end
         last_q[last_q.size() - 1] = 1'b1;
         ph = ph - TWO24;
      end
   endtask

   task automatic build_exp();
      int   n = addr_q.size();
      exp_t e;
      exp_q.delete();
      for (int j = 0; j <= n + 2; j++) begin
         e.addr = 8'd0;
         e.sv   = 1'b0;
         e.sd   = 16'd0;
         e.wrap = 1'b0;
         e.bs   = (j <= n);
         e.dn   = (j == n + 1);
         if (j < n) e.addr = 8'(addr_q[j]);
         if (j >= 1 && j <= n) begin
            e.sv   = 1'b1;
            e.sd   = rom[7'(addr_q[j-1])];
            e.wrap = last_q[j-1];
         end
         exp_q.push_back(e);
      end
      addr_q.delete();
      last_q.delete();
   endtask

   task automatic compare_run();
      exp_t e;
      int   j = 0;
      nv = 0;
      nw = 0;
      dlog.delete();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         @(negedge clk);
         chk($sformatf("rom_addr@%0d", j), 32'(rom_addr), 32'(e.addr));
         chk($sformatf("samp_valid@%0d", j), 32'(samp_valid), 32'(e.sv));
         if (e.sv) chk($sformatf("samp_data@%0d", j), 32'(samp_data), 32'(e.sd));
         chk($sformatf("cycle_wrap@%0d", j), 32'(cycle_wrap), 32'(e.wrap));
         chk($sformatf("done@%0d", j), 32'(done), 32'(e.dn));
         chk($sformatf("busy@%0d", j), 32'(busy), 32'(e.bs));
         if (samp_valid) begin
            nv++;
            dlog.push_back(samp_data);
         end
         if (cycle_wrap) nw++;
         j++;
      end
   endtask

   task automatic cfg(input logic [23:0] f, input logic [15:0] c);
      @(posedge clk); #1;
      cfg_valid = 1'b1; cfg_ftw = f; cfg_cycles = c;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
   endtask

   task automatic pulse_start(input logic with_stop);
      @(posedge clk); #1;
      start = 1'b1; stop = with_stop;
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
   endtask

   longint ph;

   initial begin
      nreset = 1'b0; start = 1'b0; stop = 1'b0;
      cfg_valid = 1'b0; cfg_ftw = 24'd0; cfg_cycles = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_samp_valid", 32'(samp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cycle_wrap", 32'(cycle_wrap), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      nreset = 1'b1;

      // Single period, one address per clock
      cfg(F17, 16'd1);
      ph = 0; add_periods(1, F17, ph); build_exp();
      pulse_start(1'b0);
      compare_run();
      chk("t1_nvalid", 32'(nv), 32'd128);
      if (dlog.size() == 128) begin
         chk("t1_first", 32'(dlog[0]), 32'd800);
         chk("t1_second", 32'(dlog[1]), 32'd831);
         chk("t1_last", 32'(dlog[127]), 32'd769);
      end

      // Three periods at double step
      cfg(F18, 16'd3);
      ph = 0; add_periods(3, F18, ph); build_exp();
      pulse_start(1'b0);
      compare_run();
      chk("t2_nvalid", 32'(nv), 32'd192);
      chk("t2_nwrap", 32'(nw), 32'd3);

      // Continuous run, stop at address 40 completes the period
      cfg(F17, 16'd0);
      ph = 0; add_periods(1, F17, ph); build_exp();
      pulse_start(1'b0);
      fork
         compare_run();
         begin
            repeat (40) @(posedge clk);
            #1; stop = 1'b1;
            @(posedge clk); #1; stop = 1'b0;
         end
      join
      chk("t3_nvalid", 32'(nv), 32'd128);

      // Retune mid-period through the shadow register
      cfg(F17, 16'd2);
      ph = 0; add_periods(1, F17, ph); add_periods(1, F18, ph); build_exp();
      pulse_start(1'b0);
      fork
         compare_run();
         begin
            repeat (10) @(posedge clk);
            #1;
            chk("t4_ready_before", 32'(cfg_ready), 32'd1);
            cfg_valid = 1'b1; cfg_ftw = F18; cfg_cycles = 16'd2;
            @(posedge clk); #1;
            cfg_valid = 1'b0;
            chk("t4_ready_full", 32'(cfg_ready), 32'd0);
            repeat (116) @(posedge clk);
            #1;
            chk("t4_ready_held", 32'(cfg_ready), 32'd0);
            @(posedge clk); #1;
            chk("t4_ready_free", 32'(cfg_ready), 32'd1);
         end
      join
      chk("t4_nwrap", 32'(nw), 32'd2);

      // Reset mid-run clears outputs and the active config
      cfg(F17, 16'd0);
      pulse_start(1'b0);
      repeat (20) @(posedge clk);
      #1;
      chk("t5_busy_running", 32'(busy), 32'd1);
      nreset = 1'b0;
      #1;
      chk("t5_rom_addr", 32'(rom_addr), 32'd0);
      chk("t5_samp_valid", 32'(samp_valid), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_cycle_wrap", 32'(cycle_wrap), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      chk("t5_cfg_ready", 32'(cfg_ready), 32'd1);
      @(posedge clk); #1;
      nreset = 1'b1;
      pulse_start(1'b0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t5_idle_busy", 32'(busy), 32'd0);
         chk("t5_idle_valid", 32'(samp_valid), 32'd0);
      end

      // Zero tuning word ignored; start with stop runs the full programmed count
      cfg(24'd0, 16'd1);
      pulse_start(1'b0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t6_zero_ftw_busy", 32'(busy), 32'd0);
      end
      cfg(F18, 16'd2);
      ph = 0; add_periods(2, F18, ph); build_exp();
      pulse_start(1'b1);
      compare_run();
      chk("t6_nvalid", 32'(nv), 32'd128);
      chk("t6_nwrap", 32'(nw), 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
